// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus bundle: instruction memory read port plus the
// valid/ready handshake towards the IF/ID pipeline register.
interface instruction_fetch_if #(
    parameter int INSTR_WIDTH = 14,
    parameter int PC_WIDTH    = 8
) ();

    // Instruction memory side
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_data;

    // IF/ID side
    logic                   valid_out;
    logic [INSTR_WIDTH-1:0] instruction_out;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   out_ready;

    // Fetch unit view
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data,
        output valid_out,
        output instruction_out,
        output pc_out,
        input  out_ready
    );

    // Memory / consumer view
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data,
        input  valid_out,
        input  instruction_out,
        input  pc_out,
        output out_ready
    );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC generation, single-outstanding instruction
// memory reads, one-entry output buffer and redirect/wrong-path discard.
module instruction_fetch #(
    parameter int          INSTR_WIDTH = 14,
    parameter int          PC_WIDTH    = 8,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    instruction_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic                   req_q;
    logic [PC_WIDTH-1:0]    addr_q;
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_out_q;

    logic                   transfer;
    logic                   can_issue;

    // A buffered instruction leaves only when no redirect flushes it.
    assign transfer  = valid_q && bus.out_ready && !redirect_valid;
    // Issue only when the buffer is free now or is emptied on this edge.
    assign can_issue = fetch_en && !redirect_valid && (!valid_q || bus.out_ready);

    assign bus.imem_req        = req_q;
    assign bus.imem_addr       = addr_q;
    assign bus.valid_out       = valid_q;
    assign bus.instruction_out = instr_q;
    assign bus.pc_out          = pc_out_q;

    // Fetch FSM with registered memory request and output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= PC_WIDTH'(RESET_PC);
            req_q    <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            // Buffer drain / flush; a completing fetch below overrides this.
            if (redirect_valid || transfer) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (can_issue) begin
                        req_q  <= 1'b1;
                        addr_q <= pc;
                        state  <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.imem_ready) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                        if (redirect_valid) begin
                            pc <= redirect_pc;
                        end else begin
                            instr_q  <= bus.imem_data;
                            pc_out_q <= addr_q;
                            valid_q  <= 1'b1;
                            pc       <= pc + PC_WIDTH'(1);
                        end
                    end else if (redirect_valid) begin
                        // Request must stay up with its address; just retarget pc.
                        pc    <= redirect_pc;
                        state <= DISCARD;
                    end
                end

                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (bus.imem_ready) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: an 8-bit-PC instance for stream,
// backpressure and redirect cases, and a 4-bit-PC instance for PC wrap and
// mid-request reset.
module tb_instruction_fetch;

    typedef struct {
        logic [7:0]  pc;
        logic [13:0] instr;
    } exp_t;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Instance A: PC_WIDTH=8, RESET_PC=0
    logic       rst_n = 1'b0;
    logic       fetch_en = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = '0;
    int         mem_lat = 1;
    int         cnt_a = 0;
    logic [7:0] held_a = '0;
    exp_t       q_a[$];

    // Instance B: PC_WIDTH=4, RESET_PC=14
    logic       rst_n_b = 1'b0;
    logic       fetch_en_b = 1'b0;
    logic       redirect_valid_b = 1'b0;
    logic [3:0] redirect_pc_b = '0;
    int         cnt_b = 0;
    exp_t       q_b[$];

    instruction_fetch_if #(.INSTR_WIDTH(14), .PC_WIDTH(8)) bus_a ();
    instruction_fetch_if #(.INSTR_WIDTH(14), .PC_WIDTH(4)) bus_b ();

    instruction_fetch #(.INSTR_WIDTH(14), .PC_WIDTH(8), .RESET_PC(0)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus_a.master)
    );

    instruction_fetch #(.INSTR_WIDTH(14), .PC_WIDTH(4), .RESET_PC(14)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n_b),
        .fetch_en       (fetch_en_b),
        .redirect_valid (redirect_valid_b),
        .redirect_pc    (redirect_pc_b),
        .bus            (bus_b.master)
    );

    always #5 clk = ~clk;

    assign bus_a.imem_data = 14'h100 + {6'b0, bus_a.imem_addr};
    assign bus_b.imem_data = 14'h100 + {10'b0, bus_b.imem_addr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory A: ready after mem_lat cycles of request; checks address hold.
    always @(posedge clk) begin
        #1;
        if (!rst_n || !bus_a.imem_req) begin
            cnt_a = 0;
            bus_a.imem_ready = 1'b0;
        end else begin
            cnt_a++;
            if (cnt_a == 1) held_a = bus_a.imem_addr;
            else check("mem_a_addr_hold", bus_a.imem_addr, held_a);
            bus_a.imem_ready = (cnt_a >= mem_lat);
        end
    end

    // Memory B: fixed 1-cycle latency.
    always @(posedge clk) begin
        #1;
        if (!rst_n_b || !bus_b.imem_req) begin
            cnt_b = 0;
            bus_b.imem_ready = 1'b0;
        end else begin
            cnt_b++;
            bus_b.imem_ready = (cnt_b >= 1);
        end
    end

    // Monitor A: compare every handshake transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus_a.valid_out && bus_a.out_ready && !redirect_valid) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected: actual pc=%0h expected none", bus_a.pc_out);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_pc_out", bus_a.pc_out, e.pc);
                check("a_instr_out", bus_a.instruction_out, e.instr);
            end
        end
    end

    // Monitor B: compare every handshake transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst_n_b && bus_b.valid_out && bus_b.out_ready && !redirect_valid_b) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: actual pc=%0h expected none", bus_b.pc_out);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_pc_out", {4'b0, bus_b.pc_out}, e.pc);
                check("b_instr_out", bus_b.instruction_out, e.instr);
            end
        end
    end

    task automatic push_a(input logic [7:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = 14'h100 + {6'b0, pc};
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] pc);
        exp_t e;
        e.pc = {4'b0, pc};
        e.instr = 14'h100 + {10'b0, pc};
        q_b.push_back(e);
    endtask

    task automatic do_reset(input logic fe, input logic ordy, input int lat);
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        bus_a.out_ready = 1'b0;
        tick();
        tick();
        mem_lat = lat;
        fetch_en = fe;
        bus_a.out_ready = ordy;
        #2;
        rst_n = 1'b1;
    endtask

    // Bounded wait for the next rising imem_req on A, then check its address.
    task automatic wait_req_rise(input logic [7:0] addr);
        logic prev;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev = bus_a.imem_req;
            tick();
            if (bus_a.imem_req && !prev) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL req_timeout: actual no request expected addr=%0h", addr);
        end else begin
            check("req_addr", bus_a.imem_addr, addr);
        end
    endtask

    task automatic drain_a(input int n);
        for (int i = 0; i < n; i++) tick();
        check("a_queue_empty", q_a.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        bus_a.imem_ready = 1'b0;
        bus_b.imem_ready = 1'b0;

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 5; i++) begin
            fetch_en = 1'($urandom_range(0, 1));
            bus_a.out_ready = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc = 8'($urandom_range(0, 255));
            tick();
            check("rst_req", bus_a.imem_req, 0);
            check("rst_addr", bus_a.imem_addr, 0);
            check("rst_valid", bus_a.valid_out, 0);
            check("rst_instr", bus_a.instruction_out, 0);
            check("rst_pc_out", bus_a.pc_out, 0);
        end

        // Stream with 1-cycle memory: one instruction every 2 cycles.
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        mem_lat = 1;
        for (int k = 0; k < 4; k++) push_a(8'(k));
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_req", bus_a.imem_req, 1);
            check("stream_addr", bus_a.imem_addr, k);
            check("stream_gap", bus_a.valid_out, 0);
            tick();
            if (k == 3) fetch_en = 1'b0;
            check("stream_valid", bus_a.valid_out, 1);
            check("stream_pc", bus_a.pc_out, k);
        end
        drain_a(3);

        // Backpressure: output held while out_ready=0, no new request.
        do_reset(1'b1, 1'b0, 1);
        push_a(8'h00);
        push_a(8'h01);
        wait_req_rise(8'h00);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", bus_a.valid_out, 1);
            check("bp_pc", bus_a.pc_out, 0);
            check("bp_instr", bus_a.instruction_out, 14'h100);
            check("bp_req", bus_a.imem_req, 0);
        end
        bus_a.out_ready = 1'b1;
        tick();
        check("bp_next_req", bus_a.imem_req, 1);
        check("bp_next_addr", bus_a.imem_addr, 1);
        fetch_en = 1'b0;
        drain_a(4);

        // Redirect while a 3-cycle request to addr 2 is in flight.
        do_reset(1'b1, 1'b1, 3);
        push_a(8'h00);
        push_a(8'h01);
        push_a(8'h40);
        wait_req_rise(8'h00);
        wait_req_rise(8'h01);
        wait_req_rise(8'h02);
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check("disc_req", bus_a.imem_req, 1);
        check("disc_addr", bus_a.imem_addr, 2);
        tick();
        check("disc_addr_hold", bus_a.imem_addr, 2);
        check("disc_no_valid", bus_a.valid_out, 0);
        wait_req_rise(8'h40);
        fetch_en = 1'b0;
        drain_a(6);

        // Redirect flushes a held output even with out_ready=1.
        do_reset(1'b1, 1'b0, 1);
        wait_req_rise(8'h00);
        tick();
        tick();
        check("held_valid", bus_a.valid_out, 1);
        check("held_pc", bus_a.pc_out, 0);
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        bus_a.out_ready = 1'b1;
        push_a(8'h10);
        tick();
        redirect_valid = 1'b0;
        check("flush_valid", bus_a.valid_out, 0);
        check("flush_no_req", bus_a.imem_req, 0);
        wait_req_rise(8'h10);
        fetch_en = 1'b0;
        drain_a(4);
        rst_n = 1'b0;

        // PC wrap on the 4-bit instance: 14, 15, 0, 1.
        fetch_en_b = 1'b1;
        bus_b.out_ready = 1'b1;
        push_b(4'd14);
        push_b(4'd15);
        push_b(4'd0);
        push_b(4'd1);
        tick();
        #2;
        rst_n_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] epc;
            epc = 4'(14 + k);
            tick();
            check("wrap_req", bus_b.imem_req, 1);
            check("wrap_addr", bus_b.imem_addr, epc);
            tick();
            check("wrap_valid", bus_b.valid_out, 1);
            check("wrap_pc", bus_b.pc_out, epc);
        end
        tick();
        check("wrap_wait_addr", bus_b.imem_addr, 2);
        check("wrap_wait_req", bus_b.imem_req, 1);

        // Asynchronous reset in the middle of the outstanding request.
        #2;
        rst_n_b = 1'b0;
        #1;
        check("arst_req", bus_b.imem_req, 0);
        check("arst_valid", bus_b.valid_out, 0);
        check("arst_pc_out", bus_b.pc_out, 0);
        tick();
        tick();
        push_b(4'd14);
        #2;
        rst_n_b = 1'b1;
        tick();
        check("restart_req", bus_b.imem_req, 1);
        check("restart_addr", bus_b.imem_addr, 14);
        fetch_en_b = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("b_queue_empty", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
